// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM states, M-field bit
// positions and the default request timeout.
package mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int MEM_READ        = 1;
  localparam int MEM_WRITE       = 0;
  localparam int TIMEOUT_DEFAULT = 255;

  // Any of MemRead/MemWrite on a valid instruction makes it a memory op.
  function automatic logic is_mem_op(input logic valid, input logic [1:0] m);
    return valid && (m[MEM_READ] || m[MEM_WRITE]);
  endfunction

endpackage

// File: rtl/dm_timeout_ctr.sv
// BUSY-cycle counter for outstanding data-memory requests; tc flags the
// last cycle a request may still be answered.
module dm_timeout_ctr
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tc = (count_reg == LAST);

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes non-memory instructions straight through and
// runs aligned loads/stores as a stalled request/ack handshake with timeout.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [1:0]  EX_MEM_M,
  input  logic [1:0]  EX_MEM_WB,
  input  logic [31:0] EX_MEM_ALU,
  input  logic [31:0] EX_MEM_WD,
  input  logic [4:0]  EX_MEM_WReg,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [1:0]  WB,
  output logic [4:0]  WReg,
  output logic [31:0] RD,
  output logic [31:0] ALU,
  output logic        wb_en,
  output logic        mem_stall,
  output logic        mem_fault
);

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [4:0]  wreg_reg;
  logic [1:0]  wb_reg;
  logic        we_reg;

  logic mem_op;
  logic misaligned;
  logic start;
  logic busy;
  logic tc;

  assign mem_op     = is_mem_op(in_valid, EX_MEM_M);
  assign misaligned = (EX_MEM_ALU[1:0] != 2'b00);
  assign start      = (state_reg == IDLE) && mem_op && !misaligned;
  assign busy       = (state_reg == BUSY);

  dm_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk(clk),
    .rst(rst),
    .clr(start),
    .inc(busy && !dm_ack),
    .tc (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A store wins when both MemRead and MemWrite are set, so only the write bit is kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      wreg_reg  <= '0;
      wb_reg    <= '0;
      we_reg    <= 1'b0;
    end else if (start) begin
      addr_reg  <= EX_MEM_ALU;
      wdata_reg <= EX_MEM_WD;
      wreg_reg  <= EX_MEM_WReg;
      wb_reg    <= EX_MEM_WB;
      we_reg    <= EX_MEM_M[MEM_WRITE];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = BUSY;
      BUSY: if (dm_ack || tc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wb_en     = 1'b0;
    WB        = EX_MEM_WB;
    WReg      = EX_MEM_WReg;
    ALU       = EX_MEM_ALU;
    RD        = '0;
    mem_stall = 1'b0;
    mem_fault = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_op) begin
          if (misaligned) begin
            wb_en     = 1'b1;
            WB        = 2'b00;
            mem_fault = 1'b1;
          end else begin
            mem_stall = 1'b1;
          end
        end else begin
          wb_en = in_valid;
        end
      end
      BUSY: begin
        WB   = wb_reg;
        WReg = wreg_reg;
        ALU  = addr_reg;
        // An ack arriving on the terminal-count cycle still completes normally.
        if (dm_ack) begin
          wb_en = 1'b1;
          RD    = we_reg ? 32'h0 : dm_rdata;
        end else if (tc) begin
          wb_en     = 1'b1;
          WB        = 2'b00;
          mem_fault = 1'b1;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: begin
        wb_en = 1'b0;
      end
    endcase
  end

  assign dm_req   = busy;
  assign dm_we    = busy && we_reg;
  assign dm_addr  = busy ? addr_reg : 32'h0;
  assign dm_wdata = busy ? wdata_reg : 32'h0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a transaction-level model checked every
// negative edge, plus hand-computed literal expectations per scenario.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  m_in = 2'b00;
  logic [1:0]  wb_in = 2'b00;
  logic [31:0] alu_in = 32'h0;
  logic [31:0] wd_in = 32'h0;
  logic [4:0]  wreg_in = 5'd0;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = 32'h0;

  logic        dm_req, dm_we, wb_en, mem_stall, mem_fault;
  logic [31:0] dm_addr, dm_wdata, RD, ALU;
  logic [1:0]  WB;
  logic [4:0]  WReg;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .EX_MEM_M(m_in), .EX_MEM_WB(wb_in), .EX_MEM_ALU(alu_in),
    .EX_MEM_WD(wd_in), .EX_MEM_WReg(wreg_in),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .WB(WB), .WReg(WReg), .RD(RD), .ALU(ALU),
    .wb_en(wb_en), .mem_stall(mem_stall), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one outstanding request, aged in BUSY cycles.
  bit          m_busy = 0, n_busy = 0;
  int          m_age = 0, n_age = 0;
  logic [31:0] m_addr = 0, n_addr = 0, m_wd = 0, n_wd = 0;
  logic [4:0]  m_wreg = 0, n_wreg = 0;
  logic [1:0]  m_wb = 0, n_wb = 0;
  bit          m_store = 0, n_store = 0;

  logic        e_req, e_we, e_stall, e_fault, e_wben;
  logic [31:0] e_addr, e_wdata, e_alu, e_rd;
  logic [1:0]  e_wb;
  logic [4:0]  e_wreg;

  always @(negedge clk) begin
    if (!rst) m_busy = 0;
    n_busy = m_busy; n_age = m_age; n_addr = m_addr; n_wd = m_wd;
    n_wreg = m_wreg; n_wb = m_wb; n_store = m_store;
    e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_stall = 0; e_fault = 0;
    e_wben = 0; e_wb = wb_in; e_wreg = wreg_in; e_alu = alu_in; e_rd = 0;
    if (!m_busy) begin
      if (in_valid && m_in != 2'b00) begin
        if (alu_in[1:0] != 2'b00) begin
          e_wben = 1; e_wb = 2'b00; e_fault = 1;
        end else begin
          e_stall = 1; n_busy = 1; n_age = 0; n_addr = alu_in; n_wd = wd_in;
          n_wreg = wreg_in; n_wb = wb_in; n_store = m_in[0];
        end
      end else begin
        e_wben = in_valid;
      end
    end else begin
      e_req = 1; e_we = m_store; e_addr = m_addr; e_wdata = m_wd;
      e_wb = m_wb; e_wreg = m_wreg; e_alu = m_addr;
      if (dm_ack) begin
        e_wben = 1; e_rd = m_store ? 32'h0 : dm_rdata; n_busy = 0;
      end else if (m_age + 1 == TO) begin
        e_wben = 1; e_wb = 2'b00; e_fault = 1; n_busy = 0;
      end else begin
        e_stall = 1; n_age = m_age + 1;
      end
    end
    check("m.dm_req", 32'(dm_req), 32'(e_req));
    check("m.dm_we", 32'(dm_we), 32'(e_we));
    check("m.dm_addr", dm_addr, e_addr);
    check("m.dm_wdata", dm_wdata, e_wdata);
    check("m.mem_stall", 32'(mem_stall), 32'(e_stall));
    check("m.mem_fault", 32'(mem_fault), 32'(e_fault));
    check("m.wb_en", 32'(wb_en), 32'(e_wben));
    if (e_wben) begin
      check("m.WB", 32'(WB), 32'(e_wb));
      check("m.WReg", 32'(WReg), 32'(e_wreg));
      check("m.ALU", ALU, e_alu);
      check("m.RD", RD, e_rd);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_busy = n_busy; m_age = n_age; m_addr = n_addr; m_wd = n_wd;
      m_wreg = n_wreg; m_wb = n_wb; m_store = n_store;
    end
  end

  task automatic drive(input logic v, input logic [1:0] mm, input logic [1:0] wb,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    in_valid = v; m_in = mm; wb_in = wb; alu_in = a; wd_in = d; wreg_in = r;
  endtask

  task automatic set_ack(input logic a, input logic [31:0] rd);
    dm_ack = a; dm_rdata = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int stall_cnt;

  initial begin
    #3;
    check("reset.dm_req", 32'(dm_req), 32'h0);
    check("reset.dm_we", 32'(dm_we), 32'h0);
    check("reset.mem_fault", 32'(mem_fault), 32'h0);
    check("reset.dm_addr", dm_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    $display("txn: ALU pass-through");
    drive(1, 2'b00, 2'b10, 32'h10, 32'h0, 5'd3);
    #2;
    check("alu.wb_en", 32'(wb_en), 32'h1);
    check("alu.ALU", ALU, 32'h10);
    check("alu.WReg", 32'(WReg), 32'h3);
    check("alu.WB", 32'(WB), 32'h2);
    check("alu.RD", RD, 32'h0);
    check("alu.stall", 32'(mem_stall), 32'h0);

    $display("txn: load 0x100, ack after 3 BUSY cycles");
    next_cycle();
    drive(1, 2'b10, 2'b01, 32'h100, 32'h0, 5'd7);
    #2;
    stall_cnt = mem_stall ? 1 : 0;
    check("ld.entry_wb_en", 32'(wb_en), 32'h0);
    check("ld.entry_req", 32'(dm_req), 32'h0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #2;
      if (mem_stall) stall_cnt++;
      check("ld.busy_req", 32'(dm_req), 32'h1);
      check("ld.busy_addr", dm_addr, 32'h100);
    end
    next_cycle();
    set_ack(1, 32'hDEADBEEF);
    #2;
    check("ld.stall_cycles", 32'(stall_cnt), 32'd4);
    check("ld.ack_stall", 32'(mem_stall), 32'h0);
    check("ld.RD", RD, 32'hDEADBEEF);
    check("ld.wb_en", 32'(wb_en), 32'h1);
    check("ld.ack_on_tc_fault", 32'(mem_fault), 32'h0);
    next_cycle();
    set_ack(0, 32'h0);
    drive(0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    #2;
    check("ld.after_req", 32'(dm_req), 32'h0);

    $display("txn: store 0x204 <- 0x55, immediate ack");
    next_cycle();
    drive(1, 2'b01, 2'b10, 32'h204, 32'h55, 5'd9);
    next_cycle();
    set_ack(1, 32'hFFFF_FFFF);
    #2;
    check("st.dm_we", 32'(dm_we), 32'h1);
    check("st.dm_wdata", dm_wdata, 32'h55);
    check("st.wb_en", 32'(wb_en), 32'h1);
    check("st.RD", RD, 32'h0);
    next_cycle();
    set_ack(0, 32'h0);
    drive(0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    #2;
    check("st.after_we", 32'(dm_we), 32'h0);
    check("st.after_wdata", dm_wdata, 32'h0);

    $display("txn: misaligned load 0x102");
    next_cycle();
    drive(1, 2'b10, 2'b11, 32'h102, 32'h0, 5'd4);
    #2;
    check("mis.fault", 32'(mem_fault), 32'h1);
    check("mis.wb_en", 32'(wb_en), 32'h1);
    check("mis.WB", 32'(WB), 32'h0);
    check("mis.req", 32'(dm_req), 32'h0);
    next_cycle();
    drive(0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    #2;
    check("mis.after_req", 32'(dm_req), 32'h0);

    $display("txn: load 0x300, no ack, timeout");
    next_cycle();
    drive(1, 2'b10, 2'b10, 32'h300, 32'h0, 5'd5);
    for (int i = 1; i <= TO; i++) begin
      next_cycle();
      #2;
      check("to.req", 32'(dm_req), 32'h1);
      check("to.fault", 32'(mem_fault), (i == TO) ? 32'h1 : 32'h0);
    end
    check("to.WB", 32'(WB), 32'h0);
    check("to.wb_en", 32'(wb_en), 32'h1);
    next_cycle();
    drive(0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    #2;
    check("to.after_req", 32'(dm_req), 32'h0);

    $display("txn: M=11 at 0x40 acts as store");
    next_cycle();
    drive(1, 2'b11, 2'b01, 32'h40, 32'hA5A5_0000, 5'd6);
    next_cycle();
    set_ack(1, 32'h1234_5678);
    #2;
    check("rw.dm_we", 32'(dm_we), 32'h1);
    check("rw.RD", RD, 32'h0);
    next_cycle();
    drive(0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    set_ack(1, 32'hCAFE);
    #2;
    check("idle_ack.wb_en", 32'(wb_en), 32'h0);
    check("idle_ack.req", 32'(dm_req), 32'h0);
    next_cycle();
    set_ack(0, 32'h0);

    $display("txn: load 0x80, reset while BUSY");
    drive(1, 2'b10, 2'b01, 32'h80, 32'h0, 5'd2);
    next_cycle();
    #2;
    check("rb.busy_req", 32'(dm_req), 32'h1);
    rst = 1'b0;
    drive(0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    #1;
    check("rb.async_req", 32'(dm_req), 32'h0);
    next_cycle();
    rst = 1'b1;
    set_ack(1, 32'h0BAD);
    #2;
    check("rb.ack_wb_en", 32'(wb_en), 32'h0);
    check("rb.ack_req", 32'(dm_req), 32'h0);
    next_cycle();
    set_ack(0, 32'h0);

    $display("txn: back-to-back loads 0x10 and 0x14");
    drive(1, 2'b10, 2'b10, 32'h10, 32'h0, 5'd11);
    next_cycle();
    set_ack(1, 32'h1111_0000);
    #2;
    check("bb.RD0", RD, 32'h1111_0000);
    next_cycle();
    set_ack(0, 32'h0);
    drive(1, 2'b10, 2'b11, 32'h14, 32'h0, 5'd12);
    next_cycle();
    next_cycle();
    set_ack(1, 32'h2222_0000);
    #2;
    check("bb.RD1", RD, 32'h2222_0000);
    check("bb.addr1", dm_addr, 32'h14);
    next_cycle();
    set_ack(0, 32'h0);
    drive(1, 2'b00, 2'b01, 32'h7, 32'h0, 5'd31);
    next_cycle();
    drive(0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    repeat (3) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
